// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
// - div_state_t : FSM states, IDLE -> PREP -> RUN -> FIX -> DONE
// - LO_SLOT / HI_SLOT : word slots of the packed 2*WIDTH result. This is the same
//   HI/LO layout as the multiplier product, so the shared write path can take
//   either unit's result: LO = quotient, HI = remainder.
package div_seq_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

  localparam int unsigned LO_SLOT = 0;
  localparam int unsigned HI_SLOT = 1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   r      in  WIDTH  partial remainder
//   q      in  WIDTH  quotient / remaining dividend bits
//   d      in  WIDTH  divisor magnitude
//   r_next out WIDTH  partial remainder after this iteration
//   q_next out WIDTH  quotient after this iteration (new bit at LSB)
module div_step
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Shift {r,q} left by one. The shifted remainder needs WIDTH+1 bits.
    rs = {r, q[WIDTH-1]};
    ge = (rs >= {1'b0, d});
    // If the subtraction is kept, the result is below d, so it fits in WIDTH bits.
    diff = rs[WIDTH-1:0] - d;
    if (ge) begin
      r_next = diff;
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = rs[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned integer divider. It uses the radix-2 restoring
// algorithm and produces one quotient bit per clock.
// Parameters:
//   WIDTH  operand width; C is 2*WIDTH wide
//   SIGNED 1 = two's-complement division (truncates toward zero), 0 = unsigned
// Ports:
//   clock  in   rising-edge clock
//   clear  in   synchronous active-low reset; aborts any operation
//   start  in   request, sampled only in IDLE
//   A, B   in   dividend and divisor, captured when start is accepted
//   busy   out  high from the cycle after an accepted start through FIX
//   done   out  one-cycle pulse; C is valid from this cycle
//   dz     out  divide-by-zero flag, valid with done and held with C
//   C      out  {remainder, quotient}, held until the next FIX or reset
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               dz,
  output logic [2*WIDTH-1:0] C
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] r, q, d;
  logic             qneg, rneg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_next, q_next;
  logic [WIDTH-1:0] quo, rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_comb begin
    a_mag = (SIGNED && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    b_mag = (SIGNED && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    // Divide by zero returns the raw dividend and an all-ones quotient,
    // with no sign correction.
    if (dz) begin
      quo = '1;
      rem = a_reg;
    end else begin
      quo = qneg ? -q : q;
      rem = rneg ? -r : r;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= DIV_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      C     <= '0;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            dz    <= 1'b0;
            busy  <= 1'b1;
            state <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          qneg <= SIGNED && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          rneg <= SIGNED && a_reg[WIDTH-1];
          r    <= '0;
          q    <= a_mag;
          d    <= b_mag;
          cnt  <= CW'(WIDTH - 1);
          if (b_reg == '0) begin
            dz    <= 1'b1;
            state <= DIV_FIX;
          end else begin
            state <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          r <= r_next;
          q <= q_next;
          if (cnt == '0) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_FIX: begin
          C[HI_SLOT*WIDTH +: WIDTH] <= rem;
          C[LO_SLOT*WIDTH +: WIDTH] <= quo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DIV_DONE;
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq. A signed and an unsigned instance share the
// same stimulus. Directed cases are checked against constants. Random cases are
// checked against a reference built on plain integer division.
module tb_div_seq;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy_s, done_s, dz_s;
  logic          busy_u, done_u, dz_u;
  logic [2*W-1:0] c_s, c_u;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_seq #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clock (clock), .clear (clear), .start (start), .A (A), .B (B),
    .busy (busy_s), .done (done_s), .dz (dz_s), .C (c_s)
  );

  div_seq #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clock (clock), .clear (clear), .start (start), .A (A), .B (B),
    .busy (busy_u), .done (done_u), .dz (dz_u), .C (c_u)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer division truncates toward zero, and % takes the
  // sign of the dividend. The most-negative / -1 case wraps on truncation.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn, output bit dzo);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      dzo = 1'b1;
      return {a, 32'hFFFF_FFFF};
    end
    dzo = 1'b0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Called at a negedge. Returns at the negedge of cycle 1 with A/B scrambled.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(inout int cyc);
    while (done_s !== 1'b1 && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Full operation checked against the model. Returns at the negedge after done.
  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic [63:0] es, eu;
    bit ds, du;
    es = model(a, b, 1'b1, ds);
    eu = model(a, b, 1'b0, du);
    launch(a, b);
    cyc = 1;
    wait_done(cyc);
    chk({tag, " latency"}, 64'(cyc), (b == 32'd0) ? 64'd3 : 64'(W + 3));
    chk({tag, " C signed"}, c_s, es);
    chk({tag, " dz signed"}, 64'(dz_s), 64'(ds));
    chk({tag, " C unsigned"}, c_u, eu);
    chk({tag, " dz unsigned"}, 64'(dz_u), 64'(du));
    @(negedge clock);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [31:0] ra, rb;

    // Reset, with start held high to show that reset wins.
    A = 32'd5; B = 32'd1; start = 1'b1; clear = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset busy", 64'(busy_s), 64'd0);
    chk("reset busy u", 64'(busy_u), 64'd0);
    chk("reset done", 64'(done_s), 64'd0);
    chk("reset dz", 64'(dz_s), 64'd0);
    chk("reset C", c_s, 64'd0);
    start = 1'b0; clear = 1'b1;
    @(negedge clock);

    run_check("28/5", 32'd28, 32'd5);
    chk("28/5 const", c_s, {32'd3, 32'd5});
    chk("28/5 done pulse", 64'(done_s), 64'd0);
    run_check("-28/5", -32'd28, 32'd5);
    chk("-28/5 const", c_s, {32'hFFFF_FFFD, 32'hFFFF_FFFB});
    run_check("28/-5", 32'd28, -32'd5);
    chk("28/-5 const", c_s, {32'd3, 32'hFFFF_FFFB});
    run_check("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf const", c_s, {32'd0, 32'h8000_0000});
    chk("ovf dz", 64'(dz_s), 64'd0);
    run_check("uns ffffffff/2", 32'hFFFF_FFFF, 32'd2);
    chk("uns const", c_u, {32'd1, 32'h7FFF_FFFF});
    run_check("1234/0", 32'd1234, 32'd0);
    chk("dz const", c_s, {32'd1234, 32'hFFFF_FFFF});
    chk("dz flag", 64'(dz_s), 64'd1);

    // dz clears on the next accepted start. C holds until FIX.
    launch(32'd100, 32'd7);
    chk("dz cleared", 64'(dz_s), 64'd0);
    chk("busy after start", 64'(busy_s), 64'd1);
    chk("C held", c_s, {32'd1234, 32'hFFFF_FFFF});
    cyc = 1;
    wait_done(cyc);
    chk("100/7 latency", 64'(cyc), 64'(W + 3));
    chk("100/7 const", c_s, {32'd2, 32'd14});
    @(negedge clock);

    // A start during RUN is ignored.
    launch(32'd28, 32'd5);
    repeat (8) @(negedge clock);
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 10;
    wait_done(cyc);
    chk("midstart latency", 64'(cyc), 64'(W + 3));
    chk("midstart C", c_s, {32'd3, 32'd5});

    // A start during DONE is ignored; the same start held into IDLE is accepted.
    A = 32'd50; B = 32'd7; start = 1'b1;
    @(negedge clock);
    chk("start in DONE ignored", 64'(busy_s), 64'd0);
    @(negedge clock);
    start = 1'b0; A = $urandom; B = $urandom;
    chk("start in IDLE accepted", 64'(busy_s), 64'd1);
    cyc = 1;
    repeat (4) begin
      @(negedge clock);
      cyc++;
    end
    chk("C held mid-op", c_s, {32'd3, 32'd5});
    wait_done(cyc);
    chk("50/7 latency", 64'(cyc), 64'(W + 3));
    chk("50/7 const", c_s, {32'd1, 32'd7});
    @(negedge clock);

    // Reset mid-operation aborts the operation with no done pulse.
    launch(32'd999, 32'd7);
    repeat (18) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("abort busy", 64'(busy_s), 64'd0);
    chk("abort done", 64'(done_s), 64'd0);
    chk("abort C", c_s, 64'd0);
    clear = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clock);
      if (done_s === 1'b1) pulses++;
    end
    chk("abort no done", 64'(pulses), 64'd0);

    // Random operands, with boundary cases mixed in. Consecutive operations are back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_check("random", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
